// File: rtl/finger_pattern_tx_if.sv
// ============================================================================
// Module   : finger_pattern_tx_if
// Brief    : Value handshake between a count source and finger_pattern_tx.
//            master = source of values, slave = finger_pattern_tx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface finger_pattern_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_value;

  modport master (output in_valid, output in_value, input in_ready);
  modport slave  (input in_valid, input in_value, output in_ready);
endinterface

`default_nettype wire

// File: rtl/finger_pattern_tx.sv
// ============================================================================
// Module   : finger_pattern_tx
// Brief    : Turns a count 0..4 into a thermometer pattern on the a..d finger
//            lines. Each value is held HOLD_CYCLES cycles and then followed by
//            GAP_CYCLES cycles of zeros. Values 5..7 are rejected with err.
//            Optional macro FINGER_TX_QUEUE_EN adds a QDEPTH-entry input FIFO
//            that allows back-to-back transmissions with no idle cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module finger_pattern_tx #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int QDEPTH      = 4
) (
  input  wire logic          clk,
  input  wire logic          reset,
  finger_pattern_tx_if.slave in_if,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               d,
  output logic               busy,
  output logic               tx_done,
  output logic               err
);

  localparam int MAX_WIN = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_WIN) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       lines_q, lines_d;
  logic             busy_q, busy_d;
  logic             tx_done_q, tx_done_d;
  logic             err_q, err_d;
  logic             in_ready_q, in_ready_d;

  logic             xfer;
  logic             legal;
  logic             start_avail;
  logic [2:0]       start_value;
  logic             pop;

  // Bit 0 drives line a, bit 3 drives line d.
  function automatic logic [3:0] thermo(input logic [2:0] v);
    thermo = {v >= 3'd4, v >= 3'd3, v >= 3'd2, v >= 3'd1};
  endfunction

  assign xfer  = in_if.in_valid && in_ready_q;
  assign legal = (in_if.in_value <= 3'd4);

`ifdef FINGER_TX_QUEUE_EN
  localparam int PTR_W = $clog2(QDEPTH);

  logic [2:0]       mem_q [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push;

  // in_ready already encodes "not full", so a legal transfer always fits.
  assign push        = xfer && legal;
  assign start_avail = (count_q != '0);
  assign start_value = mem_q[rd_ptr_q];

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop) count_d = count_q + 1'b1;
    if (!push && pop) count_d = count_q - 1'b1;
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_if.in_value;
  end

  // FIFO pointer registers, flushed by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
`else
  localparam int UNUSED_QDEPTH = QDEPTH;
  logic unused_pop;

  // Without a queue the only source of a new value is a live legal transfer,
  // which can only happen in IDLE because in_ready is low while busy.
  assign start_avail = xfer && legal;
  assign start_value = in_if.in_value;
  assign unused_pop  = pop;
`endif

  // Next-state, counter and output computation for the IDLE/HOLD/GAP sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lines_d   = lines_q;
    tx_done_d = 1'b0;
    err_d     = xfer && !legal;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_avail) begin
          pop     = 1'b1;
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          lines_d = thermo(start_value);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d   = ST_GAP;
          cnt_d     = CNT_W'(GAP_CYCLES - 1);
          lines_d   = 4'b0000;
          tx_done_d = (GAP_CYCLES == 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          if (start_avail) begin
            pop     = 1'b1;
            state_d = ST_HOLD;
            cnt_d   = CNT_W'(HOLD_CYCLES - 1);
            lines_d = thermo(start_value);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d     = cnt_q - 1'b1;
          tx_done_d = (cnt_q == CNT_W'(1));
        end
      end
      default: begin
        state_d = ST_IDLE;
        lines_d = 4'b0000;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
`ifdef FINGER_TX_QUEUE_EN
    in_ready_d = (count_d != (PTR_W + 1)'(QDEPTH));
`else
    in_ready_d = (state_d == ST_IDLE);
`endif
  end

  // State and registered outputs; reset drops any in-flight value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      lines_q    <= 4'b0000;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lines_q    <= lines_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign a       = lines_q[0];
  assign b       = lines_q[1];
  assign c       = lines_q[2];
  assign d       = lines_q[3];
  assign busy    = busy_q;
  assign tx_done = tx_done_q;
  assign err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_finger_pattern_tx.sv
// ============================================================================
// Module   : tb_finger_pattern_tx
// Brief    : Self-checking bench for finger_pattern_tx: directed vector table,
//            then random traffic against a timeline-based reference model.
//            Build with FINGER_TX_QUEUE_EN to exercise the queued variant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_finger_pattern_tx;

  localparam int H  = 4;
  localparam int G  = 2;
  localparam int QD = 4;

  logic clk;
  logic rst_n;
  logic a, b, c, d, busy, tx_done, err;

  finger_pattern_tx_if bus ();

  finger_pattern_tx #(
    .HOLD_CYCLES(H),
    .GAP_CYCLES (G),
    .QDEPTH     (QD)
  ) dut (
    .clk    (clk),
    .reset  (rst_n),
    .in_if  (bus),
    .a      (a),
    .b      (b),
    .c      (c),
    .d      (d),
    .busy   (busy),
    .tx_done(tx_done),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    bit         rn;
    bit         v;
    logic [2:0] val;
    logic [3:0] lines;
    bit         busy;
    bit         ready;
    bit         done;
    bit         err;
  } vec_t;

  vec_t tbl[$];

  // Reference model: a transmission is described only by its value and the
  // number of cycles elapsed since it entered HOLD.
  bit m_active;
  int m_t;
  int m_val;
  int m_q[$];
  bit m_err;
  bit m_ready;

  function automatic logic [3:0] th(input int v);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 0; i < 4; i++) if (v > i) r[i] = 1'b1;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rn, input bit v, input int val);
    bit xfer;
    bit fin;
    if (!rn) begin
      m_active = 1'b0;
      m_t      = 0;
      m_q.delete();
      m_err    = 1'b0;
      m_ready  = 1'b1;
      return;
    end
    xfer  = v && m_ready;
    m_err = 1'b0;
`ifdef FINGER_TX_QUEUE_EN
    fin = m_active && (m_t == H + G - 1);
    if (m_active && !fin) begin
      m_t++;
    end else if (m_q.size() > 0) begin
      m_val    = m_q.pop_front();
      m_active = 1'b1;
      m_t      = 0;
    end else begin
      m_active = 1'b0;
    end
    if (xfer) begin
      if (val <= 4) m_q.push_back(val);
      else m_err = 1'b1;
    end
    m_ready = (m_q.size() != QD);
`else
    fin = 1'b0;
    if (m_active) begin
      m_t++;
      if (m_t == H + G) m_active = 1'b0;
    end else if (xfer) begin
      if (val <= 4) begin
        m_active = 1'b1;
        m_t      = 0;
        m_val    = val;
      end else begin
        m_err = 1'b1;
      end
    end
    m_ready = !m_active;
`endif
  endtask

  task automatic compare_model();
    logic [3:0] el;
    el = (m_active && m_t < H) ? th(m_val) : 4'b0000;
    check("model_lines", {28'd0, d, c, b, a}, {28'd0, el});
    check("model_busy",  {31'd0, busy},  {31'd0, m_active});
    check("model_ready", {31'd0, bus.in_ready}, {31'd0, m_ready});
    check("model_done_err", {30'd0, tx_done, err},
          {30'd0, (m_active && m_t == H + G - 1), m_err});
  endtask

  task automatic cycle(input bit rn, input bit v, input logic [2:0] val);
    rst_n        = rn;
    bus.in_valid = v;
    bus.in_value = val;
    @(posedge clk);
    model_step(rn, v, int'(val));
    #1;
    compare_model();
  endtask

  function automatic void add(input bit rn, input bit v, input logic [2:0] val,
                              input logic [3:0] lines, input bit bz, input bit rdy,
                              input bit dn, input bit er);
    vec_t e;
    e.rn = rn; e.v = v; e.val = val; e.lines = lines;
    e.busy = bz; e.ready = rdy; e.done = dn; e.err = er;
    tbl.push_back(e);
  endfunction

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_value = 3'd0;

    // Reset for three cycles.
    for (int i = 0; i < 3; i++) add(0, 0, 0, 4'b0000, 0, 1, 0, 0);
`ifdef FINGER_TX_QUEUE_EN
    // Push 1,2,3,4,1 on consecutive cycles; queue fills after the 5th push.
    add(1, 1, 1, 4'b0000, 0, 1, 0, 0);
    add(1, 1, 2, th(1),   1, 1, 0, 0);
    add(1, 1, 3, th(1),   1, 1, 0, 0);
    add(1, 1, 4, th(1),   1, 1, 0, 0);
    add(1, 1, 1, th(1),   1, 0, 0, 0);
    add(1, 0, 0, 4'b0000, 1, 0, 0, 0);
    add(1, 0, 0, 4'b0000, 1, 0, 1, 0);
    begin
      int seq[4] = '{2, 3, 4, 1};
      foreach (seq[k]) begin
        for (int i = 0; i < H; i++) add(1, 0, 0, th(seq[k]), 1, 1, 0, 0);
        add(1, 0, 0, 4'b0000, 1, 1, 0, 0);
        add(1, 0, 0, 4'b0000, 1, 1, 1, 0);
      end
    end
    add(1, 0, 0, 4'b0000, 0, 1, 0, 0);
    // Illegal value: rejected, err pulse, ready unaffected.
    add(1, 1, 7, 4'b0000, 0, 1, 0, 1);
    add(1, 0, 0, 4'b0000, 0, 1, 0, 0);
`else
    // Value 3: four HOLD cycles, two GAP cycles, done on the second.
    add(1, 1, 3, 4'b0111, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 4'b0111, 1, 0, 0, 0);
    add(1, 0, 0, 4'b0000, 1, 0, 0, 0);
    add(1, 0, 0, 4'b0000, 1, 0, 1, 0);
    add(1, 0, 0, 4'b0000, 0, 1, 0, 0);
    // Value 0 then value 4 with in_valid held: 7-cycle HOLD-to-HOLD period.
    add(1, 1, 0, 4'b0000, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 4, 4'b0000, 1, 0, 0, 0);
    add(1, 1, 4, 4'b0000, 1, 0, 1, 0);
    add(1, 1, 4, 4'b0000, 0, 1, 0, 0);
    add(1, 1, 4, 4'b1111, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 4'b1111, 1, 0, 0, 0);
    add(1, 0, 0, 4'b0000, 1, 0, 0, 0);
    add(1, 0, 0, 4'b0000, 1, 0, 1, 0);
    add(1, 0, 0, 4'b0000, 0, 1, 0, 0);
    // Value 6: illegal, single err pulse, no activity.
    add(1, 1, 6, 4'b0000, 0, 1, 0, 1);
    add(1, 0, 0, 4'b0000, 0, 1, 0, 0);
    // Value 2 with reset on the second HOLD cycle: dropped, no tx_done.
    add(1, 1, 2, 4'b0011, 1, 0, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 4'b0000, 0, 1, 0, 0);
`endif

    foreach (tbl[i]) begin
      cycle(tbl[i].rn, tbl[i].v, tbl[i].val);
      check($sformatf("vec%0d_lines", i), {28'd0, d, c, b, a}, {28'd0, tbl[i].lines});
      check($sformatf("vec%0d_busy", i),  {31'd0, busy}, {31'd0, tbl[i].busy});
      check($sformatf("vec%0d_ready", i), {31'd0, bus.in_ready}, {31'd0, tbl[i].ready});
      check($sformatf("vec%0d_done", i),  {31'd0, tx_done}, {31'd0, tbl[i].done});
      check($sformatf("vec%0d_err", i),   {31'd0, err}, {31'd0, tbl[i].err});
    end

    // Random traffic with occasional resets, checked every cycle by the model.
    for (int n = 0; n < 600; n++) begin
      bit         rn;
      bit         v;
      logic [2:0] val;
      rn  = ($urandom_range(0, 49) != 0);
      v   = ($urandom_range(0, 2) != 0);
      val = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7))
                                        : 3'($urandom_range(0, 4));
      cycle(rn, v, val);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/finger_pattern_tx.md
Name: finger_pattern_tx

Overview:
- Transmit side of the finger-switch interface: converts a numeric count into the 4-line thermometer pattern on a,b,c,d that the finger decoder consumes.
- Each accepted value is held for a fixed window, then followed by an all-zero gap, so the downstream accumulator sees one discrete event per value.
- Used as the on-FPGA stimulus source and the loopback driver for calculator bring-up.

Parameters:
- HOLD_CYCLES, 4, cycles the pattern is driven (must be >= 1)
- GAP_CYCLES, 2, cycles of all-zero lines after each pattern (must be >= 1)
- QDEPTH, 4, queue entries when FINGER_TX_QUEUE_EN is defined (power of 2, >= 2)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset (reset==0 resets at the next rising clk edge)
- in_valid  input  1  in_value is presented
- in_ready  output  1  block can accept a value this cycle
- in_value  input  3  count to send, legal range 0..4
- a  output  1  finger line 0, high when value >= 1
- b  output  1  finger line 1, high when value >= 2
- c  output  1  finger line 2, high when value >= 3
- d  output  1  finger line 3, high when value >= 4
- busy  output  1  state is not IDLE
- tx_done  output  1  one-cycle pulse on the last GAP cycle of each transmission
- err  output  1  one-cycle pulse the cycle after an illegal value (5..7) is accepted

Behaviour:
- All outputs are registered.
- Reset values: a=b=c=d=0, busy=0, tx_done=0, err=0, state=IDLE. in_ready is high in IDLE (no queue) or when the queue is not full (queue).
- Handshake: a transfer occurs on a rising edge where in_valid && in_ready. in_value is sampled only on that edge.
- FSM states: IDLE, HOLD, GAP.
- IDLE:
  - in_ready=1.
  - A legal transfer moves to HOLD at the next edge and loads the pattern and the hold counter.
  - An illegal transfer stays in IDLE, pulses err the next cycle, and drives nothing.
- HOLD:
  - a..d show the thermometer pattern for exactly HOLD_CYCLES cycles.
  - Value 0 still occupies HOLD with all lines 0, so timing is identical for every value.
  - Counter expiry moves to GAP.
- GAP:
  - a..d=0 for exactly GAP_CYCLES cycles.
  - tx_done=1 in the final GAP cycle.
  - Then move to IDLE, or to HOLD directly if the queue holds an entry.
- Latency (no queue): transfer at edge N; pattern visible from N until N+HOLD_CYCLES; zeros until N+HOLD_CYCLES+GAP_CYCLES; in_ready=0 throughout HOLD and GAP. Minimum back-to-back period is HOLD_CYCLES+GAP_CYCLES+1 cycles.
- Pattern lines change only at HOLD entry and HOLD exit; no glitching between two transmitted values.
- Counters are sized with $clog2 of the larger parameter plus 1 and never wrap during a window.
- Reset asserted mid-transmission:
  - Lines go to 0 at that edge and the state returns to IDLE.
  - The in-flight value is dropped; no tx_done is produced.
  - The queue is flushed.
- in_valid while in_ready=0 is ignored. The block does not sample it, and the source must hold its value.

Optional Feature:
- Macro: FINGER_TX_QUEUE_EN.
- Defined:
  - Adds a QDEPTH-entry FIFO on the input side; in_ready = !full.
  - Illegal values are rejected at the input (err pulse, not enqueued) and in_ready is unaffected.
  - IDLE pops when non-empty and enters HOLD at the next edge.
  - On the final GAP cycle, a non-empty queue pops directly into HOLD, giving a back-to-back period of HOLD_CYCLES+GAP_CYCLES.
  - On a full queue, a push in the same cycle as a pop is refused (in_ready=0).
  - Reset empties the queue.
- Undefined: single-register operation as described in Behaviour; in_ready is low whenever busy.

Test Plan:
- Reset with reset=0 for 3 cycles, then release -> a..d=0, busy=0, in_ready=1, tx_done=0, err=0.
- Send value 3 (HOLD=4, GAP=2) -> a=b=c=1, d=0 for 4 cycles; then 0000 for 2 cycles; tx_done high on the 2nd gap cycle; in_ready back to 1 one cycle later.
- Send value 0, then value 4 with in_valid held high -> 4 cycles of 0000 plus 2 gap cycles, then a=b=c=d=1 for 4 cycles; period between HOLD starts = 7 cycles.
- Send value 6 -> no line activity, busy stays 0, err=1 for exactly one cycle after the transfer.
- Send value 2, assert reset=0 on the 2nd HOLD cycle -> lines 0000 at that edge, no tx_done, in_ready=1 after release.
- With FINGER_TX_QUEUE_EN defined, push 1,2,3,4,1 in consecutive cycles -> in_ready drops once 4 entries are queued; outputs 1000, 1100, 1110, 1111, 1000, each a 4-cycle HOLD plus 2-cycle GAP with no IDLE cycles between.
